// File: rtl/io_port_ctrl.sv
// io_port_ctrl: device-side I/O port with RX/TX byte FIFOs and four-phase handshakes
// Ports:
//   g_clk, g_clr                 clock, async active-high reset
//   src_data/src_valid/src_ready external source into the RX FIFO
//   input_bus/in_dev_hs/in_dev_ack  RX FIFO head presented to the processor
//   output_bus/out_wr/out_dev_hs/out_dev_ack  processor writes into the TX FIFO
//   snk_data/snk_valid/snk_ready TX FIFO head to the external sink
//   rx_count/tx_count            FIFO occupancies
module io_port_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          g_clk,
    input  logic          g_clr,
    input  logic [7:0]    src_data,
    input  logic          src_valid,
    output logic          src_ready,
    output logic [7:0]    input_bus,
    output logic          in_dev_hs,
    input  logic          in_dev_ack,
    input  logic [7:0]    output_bus,
    input  logic          out_wr,
    output logic          out_dev_hs,
    output logic          out_dev_ack,
    output logic [7:0]    snk_data,
    output logic          snk_valid,
    input  logic          snk_ready,
    output logic [CW-1:0] rx_count,
    output logic [CW-1:0] tx_count
);
    localparam int AW = CW - 1;

    typedef enum logic [1:0] {I_IDLE, I_PRESENT, I_WAIT} i_state_t;
    typedef enum logic {O_IDLE, O_ACK} o_state_t;

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic          rx_push, rx_pop, tx_push, tx_pop, load;
    logic [CW-1:0] tx_count_nx;
    logic          hs_nx;
    i_state_t      i_state, i_next;
    o_state_t      o_state, o_next;

    assign rx_full   = rx_count == CW'(DEPTH);
    assign rx_empty  = rx_count == '0;
    assign tx_full   = tx_count == CW'(DEPTH);
    assign tx_empty  = tx_count == '0;
    assign src_ready = ~rx_full;
    assign rx_push   = src_valid & ~rx_full;
    assign snk_valid = ~tx_empty;
    assign snk_data  = tx_mem[tx_rp];
    assign tx_pop    = ~tx_empty & snk_ready;
    assign in_dev_hs = i_state == I_PRESENT;
    assign out_dev_ack = o_state == O_ACK;

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
            for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wp] <= src_data;
                rx_wp         <= rx_wp + 1'b1;
            end
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
            for (int i = 0; i < DEPTH; i++) tx_mem[i] <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wp] <= output_bus;
                tx_wp         <= tx_wp + 1'b1;
            end
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
            tx_count <= tx_count_nx;
        end
    end

    always_comb begin
        i_next = i_state;
        rx_pop = 1'b0;
        load   = 1'b0;
        case (i_state)
            I_IDLE:    if (!rx_empty) begin
                           i_next = I_PRESENT;
                           load   = 1'b1;
                       end
            I_PRESENT: if (in_dev_ack) begin
                           i_next = I_WAIT;
                           rx_pop = 1'b1;
                       end
            I_WAIT:    if (!in_dev_ack) i_next = I_IDLE;
            default:   i_next = I_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            i_state   <= I_IDLE;
            input_bus <= '0;
        end else begin
            i_state <= i_next;
            if (load) input_bus <= rx_mem[rx_rp];
        end
    end

    // A write into a full TX FIFO is taken only when the sink frees a slot on the same edge.
    always_comb begin
        o_next  = o_state;
        tx_push = 1'b0;
        case (o_state)
            O_IDLE:  if (out_wr && (!tx_full || tx_pop)) begin
                         o_next  = O_ACK;
                         tx_push = 1'b1;
                     end
            O_ACK:   if (!out_wr) o_next = O_IDLE;
            default: o_next = O_IDLE;
        endcase
        tx_count_nx = tx_count + CW'(tx_push) - CW'(tx_pop);
        hs_nx       = (o_next == O_IDLE) && (tx_count_nx != CW'(DEPTH));
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            o_state    <= O_IDLE;
            out_dev_hs <= 1'b0;
        end else begin
            o_state    <= o_next;
            out_dev_hs <= hs_nx;
        end
    end
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed and randomized checks of io_port_ctrl against queue-based byte models
module tb_io_port_ctrl;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          g_clk = 1'b0;
    logic          g_clr = 1'b1;
    logic [7:0]    src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [7:0]    input_bus;
    logic          in_dev_hs;
    logic          in_dev_ack = 1'b0;
    logic [7:0]    output_bus = '0;
    logic          out_wr = 1'b0;
    logic          out_dev_hs;
    logic          out_dev_ack;
    logic [7:0]    snk_data;
    logic          snk_valid;
    logic          snk_ready = 1'b0;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] tx_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];

    io_port_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .g_clk(g_clk), .g_clr(g_clr),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .input_bus(input_bus), .in_dev_hs(in_dev_hs), .in_dev_ack(in_dev_ack),
        .output_bus(output_bus), .out_wr(out_wr), .out_dev_hs(out_dev_hs), .out_dev_ack(out_dev_ack),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk_counts();
        chk("rx_count", 32'(rx_count), 32'(rxq.size()));
        chk("tx_count", 32'(tx_count), 32'(txq.size()));
    endtask

    // sink side: every byte leaving the TX FIFO must be the oldest one written
    always @(negedge g_clk) begin
        logic [7:0] exp_b;
        if (!g_clr) begin
            chk("snk_valid", 32'(snk_valid), 32'(txq.size() != 0));
            if (snk_valid && snk_ready && txq.size() != 0) begin
                exp_b = txq.pop_front();
                chk("snk_data", 32'(snk_data), 32'(exp_b));
            end
        end
    end

    task automatic push_src(input logic [7:0] b);
        logic room;
        room = rxq.size() < DEPTH;
        src_data  = b;
        src_valid = 1'b1;
        chk("src_ready", 32'(src_ready), 32'(room));
        tick();
        if (room) rxq.push_back(b);
        src_valid = 1'b0;
        chk("rx_count_push", 32'(rx_count), 32'(rxq.size()));
    endtask

    task automatic proc_read();
        logic [7:0] exp_b;
        int n = 0;
        while (!in_dev_hs && n < 20) begin
            tick();
            n++;
        end
        chk("in_hs_timeout", 32'(in_dev_hs), 32'(1));
        exp_b = rxq[0];
        chk("input_bus", 32'(input_bus), 32'(exp_b));
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("in_hs_hold", 32'(in_dev_hs), 32'(1));
            chk("input_bus_hold", 32'(input_bus), 32'(exp_b));
        end
        in_dev_ack = 1'b1;
        tick();
        void'(rxq.pop_front());
        chk("in_hs_fall", 32'(in_dev_hs), 32'(0));
        chk("rx_count_pop", 32'(rx_count), 32'(rxq.size()));
        in_dev_ack = 1'b0;
    endtask

    task automatic proc_write(input logic [7:0] b);
        int n = 0;
        while (!out_dev_hs && n < 20) begin
            tick();
            n++;
        end
        chk("out_hs_timeout", 32'(out_dev_hs), 32'(1));
        output_bus = b;
        out_wr     = 1'b1;
        tick();
        chk("out_ack_rise", 32'(out_dev_ack), 32'(1));
        txq.push_back(b);
        chk("out_hs_in_ack", 32'(out_dev_hs), 32'(0));
        chk("tx_count_push", 32'(tx_count), 32'(txq.size()));
        chk("snk_head", 32'(snk_data), 32'(txq[0]));
        out_wr = 1'b0;
        tick();
        chk("out_ack_fall", 32'(out_dev_ack), 32'(0));
    endtask

    task automatic drain_tx();
        int n = 0;
        snk_ready = 1'b1;
        while (txq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("tx_drain", 32'(txq.size()), 32'(0));
        snk_ready = 1'b0;
        chk("tx_count_drained", 32'(tx_count), 32'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_input_bus"}, 32'(input_bus), 32'(0));
        chk({tag, "_in_hs"}, 32'(in_dev_hs), 32'(0));
        chk({tag, "_out_hs"}, 32'(out_dev_hs), 32'(0));
        chk({tag, "_out_ack"}, 32'(out_dev_ack), 32'(0));
        chk({tag, "_snk_data"}, 32'(snk_data), 32'(0));
        chk({tag, "_snk_valid"}, 32'(snk_valid), 32'(0));
        chk({tag, "_rx_count"}, 32'(rx_count), 32'(0));
        chk({tag, "_tx_count"}, 32'(tx_count), 32'(0));
    endtask

    initial begin
        logic [7:0] extra;
        // reset state and release
        tick();
        tick();
        chk_all_zero("rst");
        g_clr = 1'b0;
        chk("hs_before_edge", 32'(out_dev_hs), 32'(0));
        tick();
        chk("hs_after_release", 32'(out_dev_hs), 32'(1));
        chk("in_hs_after_release", 32'(in_dev_hs), 32'(0));

        // input path with presentation latency
        push_src(8'h3C);
        chk("in_hs_latency", 32'(in_dev_hs), 32'(0));
        push_src(8'hA5);
        chk("in_hs_present", 32'(in_dev_hs), 32'(1));
        chk("input_bus_first", 32'(input_bus), 32'(8'h3C));
        proc_read();
        proc_read();
        chk("rx_empty_end", 32'(rx_count), 32'(0));

        // RX full, held byte accepted after one ack
        for (int i = 0; i < DEPTH; i++) push_src(8'($urandom));
        extra     = 8'($urandom);
        src_data  = extra;
        src_valid = 1'b1;
        chk("src_ready_full", 32'(src_ready), 32'(0));
        tick();
        chk("rx_count_full", 32'(rx_count), 32'(DEPTH));
        proc_read();
        chk("src_ready_freed", 32'(src_ready), 32'(1));
        tick();
        rxq.push_back(extra);
        src_valid = 1'b0;
        chk("rx_count_refill", 32'(rx_count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) proc_read();

        // output path
        snk_ready = 1'b1;
        proc_write(8'h81);
        proc_write(8'h7E);
        drain_tx();

        // TX full: extra write stalls until the sink frees a slot on the same edge
        for (int i = 0; i < DEPTH; i++) proc_write(8'($urandom));
        chk("out_hs_full", 32'(out_dev_hs), 32'(0));
        chk("tx_count_full", 32'(tx_count), 32'(DEPTH));
        output_bus = 8'hEE;
        out_wr     = 1'b1;
        tick();
        tick();
        chk("no_ack_full", 32'(out_dev_ack), 32'(0));
        chk("tx_count_stall", 32'(tx_count), 32'(DEPTH));
        snk_ready = 1'b1;
        tick();
        txq.push_back(8'hEE);
        snk_ready = 1'b0;
        chk("ack_simul", 32'(out_dev_ack), 32'(1));
        chk("tx_count_simul", 32'(tx_count), 32'(DEPTH));
        out_wr = 1'b0;
        tick();
        chk("ack_simul_fall", 32'(out_dev_ack), 32'(0));
        drain_tx();
        tick();
        chk("out_hs_empty", 32'(out_dev_hs), 32'(1));

        // pointer wrap over 3*DEPTH bytes
        snk_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) proc_write(8'(i));
        drain_tx();

        // randomized mix of all four activities
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: push_src(8'($urandom));
                1: if (rxq.size() != 0) proc_read();
                2: begin
                    if (txq.size() == DEPTH) snk_ready = 1'b1;
                    proc_write(8'($urandom));
                end
                default: begin
                    snk_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            endcase
            chk_counts();
        end
        drain_tx();

        // reset in the middle of both handshakes
        push_src(8'h55);
        push_src(8'h66);
        snk_ready  = 1'b0;
        output_bus = 8'h99;
        out_wr     = 1'b1;
        tick();
        chk("pre_rst_in_hs", 32'(in_dev_hs), 32'(1));
        chk("pre_rst_out_ack", 32'(out_dev_ack), 32'(1));
        g_clr = 1'b1;
        rxq.delete();
        txq.delete();
        #1;
        chk_all_zero("midrst");
        out_wr = 1'b0;
        tick();
        g_clr = 1'b0;
        tick();
        chk("hs_after_midrst", 32'(out_dev_hs), 32'(1));
        chk("in_hs_after_midrst", 32'(in_dev_hs), 32'(0));
        chk_counts();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
